// File: rtl/error_ratio_pkg.sv
// rtl/error_ratio_pkg.sv - divider state type, ratio ladder and code helper for error_ratio_checker
package error_ratio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DIV,
    ST_DONE
  } div_state_e;

  localparam int NUM_LEVELS = 8;
  localparam logic [3:0] DIV_ZERO_CODE = 4'd15;

  // Ratio thresholds in Q8 (0.125, 0.25, 0.5, 1.0, 1.5, 2.0, 3.0, 4.0)
  localparam logic [31:0] LADDER [NUM_LEVELS] = '{
    32'd32, 32'd64, 32'd128, 32'd256, 32'd384, 32'd512, 32'd768, 32'd1024
  };

  function automatic logic [3:0] ladder_code(input logic [31:0] quot);
    logic [3:0] code;
    code = '0;
    for (int k = 0; k < NUM_LEVELS; k++) begin
      if (LADDER[k] <= quot) code = code + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/ratio_divider.sv
// rtl/ratio_divider.sv - restoring divider producing floor(sum2*2^FRAC/sum1), saturated
module ratio_divider
  import error_ratio_pkg::*;
#(
  parameter int SW   = 20,
  parameter int QW   = 16,
  parameter int FRAC = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [SW-1:0] sum1_i,
  input  logic [SW-1:0] sum2_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [QW-1:0] quot_o,
  output logic          div_zero_o
);

  localparam int EW = SW + FRAC + QW;
  localparam int HW = SW + FRAC;
  localparam int CW = $clog2(QW + 1);

  div_state_e    r_state;
  div_state_e    w_next;
  logic [SW-1:0] r_sum1;
  logic [SW-1:0] r_sum2;
  logic [SW-1:0] r_rem;
  logic [QW-1:0] r_dq;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;
  logic          r_zero;

  logic [EW-1:0] w_dividend;
  logic [HW-1:0] w_hi;
  logic [SW:0]   w_trial;
  logic          w_ge;
  logic [SW-1:0] w_diff;

  assign w_dividend = EW'(r_sum2) << FRAC;
  assign w_hi       = w_dividend[EW-1:QW];
  // Quotient fits in QW bits only if the part above the iterated bits is below the divisor
  assign w_trial    = {r_rem, r_dq[QW-1]};
  assign w_ge       = w_trial >= {1'b0, r_sum1};
  assign w_diff     = w_trial[SW-1:0] - r_sum1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start_i) w_next = ST_LOAD;
      ST_LOAD: w_next = ST_DIV;
      ST_DIV:  if (r_cnt == CW'(QW - 1)) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum1 <= '0;
      r_sum2 <= '0;
      r_rem  <= '0;
      r_dq   <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_sum1 <= sum1_i;
            r_sum2 <= sum2_i;
          end
        end
        ST_LOAD: begin
          r_ovf  <= w_hi >= HW'(r_sum1);
          r_zero <= r_sum1 == '0;
          r_rem  <= w_dividend[QW+SW-1:QW];
          r_dq   <= w_dividend[QW-1:0];
          r_cnt  <= '0;
        end
        ST_DIV: begin
          r_rem <= w_ge ? w_diff : w_trial[SW-1:0];
          r_dq  <= {r_dq[QW-2:0], w_ge};
          r_cnt <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy_o     = r_state != ST_IDLE;
  assign done_o     = r_state == ST_DONE;
  assign quot_o     = r_ovf ? {QW{1'b1}} : r_dq;
  assign div_zero_o = r_zero;

endmodule

// File: rtl/error_ratio_checker.sv
// rtl/error_ratio_checker.sv - delta-sum ratio classifier with smoothing; ERROR_RATIO_DROP_CNT_EN adds drop_cnt_o
module error_ratio_checker
  import error_ratio_pkg::*;
#(
  parameter int NUM_CH   = 16,
  parameter int DW       = 17,
  parameter int QW       = 16,
  parameter int FRAC     = 8,
  parameter int SMOOTH_N = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0][DW-1:0]  delta1_i,
  input  logic [NUM_CH-1:0][DW-1:0]  delta2_i,
  input  logic                       delta_en_i,
  input  logic [DW-2:0]              delta1_thres_i,
  input  logic [DW-2:0]              delta2_thres_i,
  output logic [3:0]                 result_o,
  output logic                       result_en_o,
  output logic                       div_busy_o
`ifdef ERROR_RATIO_DROP_CNT_EN
  ,
  output logic [15:0]                drop_cnt_o
`endif
);

  localparam int AW   = DW - 1;
  localparam int SW   = AW + $clog2(NUM_CH);
  localparam int CNTW = $clog2(SMOOTH_N + 1);

  function automatic logic [AW-1:0] sat_abs(input logic [DW-1:0] d);
    logic [DW-1:0] neg;
    neg = -d;
    if (d == {1'b1, {AW{1'b0}}}) return {AW{1'b1}};
    else if (d[DW-1])            return neg[AW-1:0];
    else                         return d[AW-1:0];
  endfunction

  logic [AW-1:0]   r_abs1 [NUM_CH];
  logic [AW-1:0]   r_abs2 [NUM_CH];
  logic [AW-1:0]   r_thr1;
  logic [AW-1:0]   r_thr2;
  logic            r_s1_vld;
  logic [SW-1:0]   w_sum1;
  logic [SW-1:0]   w_sum2;
  logic [SW-1:0]   r_sum1;
  logic [SW-1:0]   r_sum2;
  logic            r_s2_vld;
  logic            w_start;
  logic            w_busy;
  logic            w_done;
  logic [QW-1:0]   w_quot;
  logic            w_div_zero;
  logic [3:0]      r_raw;
  logic            r_raw_vld;
  logic [3:0]      r_cand;
  logic [CNTW-1:0] r_cnt;
  logic [3:0]      w_cand_nxt;
  logic [CNTW-1:0] w_cnt_nxt;
  logic [3:0]      r_result;
  logic            r_result_en;

  // Thresholds travel with the deltas so a later threshold change cannot touch this sample
  always_ff @(posedge clk) begin
    if (rst) r_s1_vld <= 1'b0;
    else     r_s1_vld <= delta_en_i;
    if (delta_en_i) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_abs1[ch] <= sat_abs(delta1_i[ch]);
        r_abs2[ch] <= sat_abs(delta2_i[ch]);
      end
      r_thr1 <= delta1_thres_i;
      r_thr2 <= delta2_thres_i;
    end
  end

  always_comb begin
    w_sum1 = '0;
    w_sum2 = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (r_abs1[ch] > r_thr1 || r_abs2[ch] > r_thr2) begin
        w_sum1 = w_sum1 + SW'(r_abs1[ch]);
        w_sum2 = w_sum2 + SW'(r_abs2[ch]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_s2_vld <= 1'b0;
    else     r_s2_vld <= r_s1_vld;
    if (r_s1_vld) begin
      r_sum1 <= w_sum1;
      r_sum2 <= w_sum2;
    end
  end

  // Sums reaching a busy divider are discarded rather than queued
  assign w_start = r_s2_vld && !w_busy;

  ratio_divider #(
    .SW   (SW),
    .QW   (QW),
    .FRAC (FRAC)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (w_start),
    .sum1_i     (r_sum1),
    .sum2_i     (r_sum2),
    .busy_o     (w_busy),
    .done_o     (w_done),
    .quot_o     (w_quot),
    .div_zero_o (w_div_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_raw     <= '0;
      r_raw_vld <= 1'b0;
    end else begin
      r_raw_vld <= w_done;
      if (w_done) r_raw <= w_div_zero ? DIV_ZERO_CODE : ladder_code(32'(w_quot));
    end
  end

  always_comb begin
    w_cand_nxt = r_cand;
    w_cnt_nxt  = r_cnt;
    if (r_raw_vld) begin
      if (r_raw == r_cand) begin
        if (r_cnt != CNTW'(SMOOTH_N)) w_cnt_nxt = r_cnt + CNTW'(1);
      end else begin
        w_cand_nxt = r_raw;
        w_cnt_nxt  = CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand      <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_result_en <= 1'b0;
    end else begin
      r_cand      <= w_cand_nxt;
      r_cnt       <= w_cnt_nxt;
      r_result_en <= r_raw_vld;
      if (r_raw_vld && w_cnt_nxt == CNTW'(SMOOTH_N)) r_result <= w_cand_nxt;
    end
  end

  assign result_o    = r_result;
  assign result_en_o = r_result_en;
  assign div_busy_o  = w_busy;

`ifdef ERROR_RATIO_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst)                                                r_drop_cnt <= '0;
    else if (r_s2_vld && w_busy && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  assign drop_cnt_o = r_drop_cnt;
`endif

endmodule

// File: tb/tb_error_ratio_checker.sv
// tb/tb_error_ratio_checker.sv - directed and randomized bench for error_ratio_checker against a ratio model
module tb_error_ratio_checker;

  localparam int NUM_CH   = 16;
  localparam int DW       = 17;
  localparam int QW       = 16;
  localparam int FRAC     = 8;
  localparam int SMOOTH_N = 3;
  localparam int LAT      = QW + 5;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_CH-1:0][DW-1:0] d1;
  logic [NUM_CH-1:0][DW-1:0] d2;
  logic                      en;
  logic [DW-2:0]             thr1;
  logic [DW-2:0]             thr2;
  logic [3:0]                result;
  logic                      result_en;
  logic                      busy;
`ifdef ERROR_RATIO_DROP_CNT_EN
  logic [15:0]               drop_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int m_cand, m_cnt, m_res;

  always #5 clk = ~clk;

  error_ratio_checker #(
    .NUM_CH   (NUM_CH),
    .DW       (DW),
    .QW       (QW),
    .FRAC     (FRAC),
    .SMOOTH_N (SMOOTH_N)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .delta1_i       (d1),
    .delta2_i       (d2),
    .delta_en_i     (en),
    .delta1_thres_i (thr1),
    .delta2_thres_i (thr2),
    .result_o       (result),
    .result_en_o    (result_en),
    .div_busy_o     (busy)
`ifdef ERROR_RATIO_DROP_CNT_EN
    ,
    .drop_cnt_o     (drop_cnt)
`endif
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int abs_of(input logic [DW-1:0] v);
    int s;
    s = int'($signed(v));
    if (s < 0) s = -s;
    if (s > (1 << (DW - 1)) - 1) s = (1 << (DW - 1)) - 1;
    return s;
  endfunction

  function automatic int ref_code(input logic [NUM_CH-1:0][DW-1:0] a,
                                  input logic [NUM_CH-1:0][DW-1:0] b,
                                  input int t1, input int t2);
    int     lad [8] = '{32, 64, 128, 256, 384, 512, 768, 1024};
    longint s1, s2, q;
    int     x, y, code;
    s1 = 0;
    s2 = 0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      x = abs_of(a[ch]);
      y = abs_of(b[ch]);
      if (x > t1 || y > t2) begin
        s1 += x;
        s2 += y;
      end
    end
    if (s1 == 0) return 15;
    q = (s2 * (64'd1 << FRAC)) / s1;
    if (q > (64'd1 << QW) - 1) q = (64'd1 << QW) - 1;
    code = 0;
    for (int k = 0; k < 8; k++) if (lad[k] <= q) code++;
    return code;
  endfunction

  function automatic logic [NUM_CH-1:0][DW-1:0] fill(input int v);
    logic [NUM_CH-1:0][DW-1:0] r;
    for (int ch = 0; ch < NUM_CH; ch++) r[ch] = v[DW-1:0];
    return r;
  endfunction

  task automatic model_smooth(input int raw);
    if (raw == m_cand) begin
      if (m_cnt < SMOOTH_N) m_cnt++;
    end else begin
      m_cand = raw;
      m_cnt  = 1;
    end
    if (m_cnt == SMOOTH_N) m_res = m_cand;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) tick();
    rst    = 1'b0;
    m_cand = 0;
    m_cnt  = 0;
    m_res  = 0;
  endtask

  task automatic run_txn(input string tag,
                         input logic [NUM_CH-1:0][DW-1:0] a,
                         input logic [NUM_CH-1:0][DW-1:0] b,
                         input int t1, input int t2);
    int raw, lat;
    raw  = ref_code(a, b, t1, t2);
    d1   = a;
    d2   = b;
    thr1 = t1[DW-2:0];
    thr2 = t2[DW-2:0];
    en   = 1'b1;
    tick();
    en   = 1'b0;
    thr1 = DW'($urandom);
    thr2 = DW'($urandom);
    d1   = fill(int'($urandom));
    lat  = 0;
    for (int i = 1; i <= LAT + 10; i++) begin
      tick();
      if (i == 2) check({tag, "_busy"}, int'(busy), 1);
      if (result_en === 1'b1) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"}, lat, LAT);
    model_smooth(raw);
    check({tag, "_res"}, int'(result), m_res);
    check({tag, "_idle"}, int'(busy), 0);
    tick();
    check({tag, "_pulse1"}, int'(result_en), 0);
  endtask

  initial begin
    logic [NUM_CH-1:0][DW-1:0] a, b;
    int exp_seq [6] = '{0, 0, 0, 0, 0, 6};
    int pulses, t1, t2;
`ifdef ERROR_RATIO_DROP_CNT_EN
    int drop0;
`endif

    d1 = '0; d2 = '0; thr1 = '0; thr2 = '0;
    do_reset();
    check("rst_result", int'(result), 0);
    check("rst_result_en", int'(result_en), 0);
    check("rst_busy", int'(busy), 0);
`ifdef ERROR_RATIO_DROP_CNT_EN
    check("rst_drop", int'(drop_cnt), 0);
`endif

    for (int n = 0; n < 3; n++) begin
      run_txn("zero", fill(0), fill(0), 0, 0);
      repeat (7) tick();
    end
    check("zero_final", int'(result), 15);

    do_reset();
    for (int n = 0; n < 3; n++) run_txn("ratio2", fill(10), fill(-20), 7, 36);
    check("ratio2_final", int'(result), 6);

    do_reset();
    for (int n = 0; n < 6; n++) begin
      run_txn("smooth", fill(10), fill(n == 2 ? -4 : -20), 7, 36);
      check("smooth_seq", int'(result), exp_seq[n]);
    end

    do_reset();
    a = fill(0); b = fill(0);
    a[0] = 17'd1; b[0] = 17'd65535;
    for (int n = 0; n < 3; n++) run_txn("sat", a, b, 0, 0);
    check("sat_final", int'(result), 8);
    a = fill(0); b = fill(1);
    a[0] = 17'h10000;
    for (int n = 0; n < 3; n++) run_txn("negmax", a, b, 0, 1);
    check("negmax_final", int'(result), 0);

`ifdef ERROR_RATIO_DROP_CNT_EN
    drop0 = int'(drop_cnt);
`endif
    d1 = fill(10); d2 = fill(-20); thr1 = 7; thr2 = 36;
    en = 1'b1;
    repeat (3) tick();
    en = 1'b0;
    pulses = 0;
    for (int i = 0; i < LAT + 15; i++) begin
      tick();
      if (result_en === 1'b1) pulses++;
    end
    check("burst_pulses", pulses, 1);
    model_smooth(6);
    check("burst_res", int'(result), m_res);
`ifdef ERROR_RATIO_DROP_CNT_EN
    check("burst_drop", int'(drop_cnt) - drop0, 2);
`endif

    d1 = fill(10); d2 = fill(-20); thr1 = 7; thr2 = 36;
    en = 1'b1;
    tick();
    en = 1'b0;
    repeat (10) tick();
    check("abort_busy_before", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_cand = 0; m_cnt = 0; m_res = 0;
    check("abort_busy", int'(busy), 0);
    check("abort_result", int'(result), 0);
    check("abort_result_en", int'(result_en), 0);
    pulses = 0;
    for (int i = 0; i < LAT + 10; i++) begin
      tick();
      if (result_en === 1'b1) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    for (int n = 0; n < 3; n++) run_txn("after_abort", fill(10), fill(-20), 7, 36);
    check("after_abort_final", int'(result), 6);

    for (int n = 0; n < 16; n++) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if ($urandom_range(0, 7) == 0) begin
          a[ch] = DW'($urandom);
          b[ch] = DW'($urandom);
        end else begin
          a[ch] = DW'(int'($urandom_range(0, 4000)) - 2000);
          b[ch] = DW'(int'($urandom_range(0, 4000)) - 2000);
        end
      end
      t1 = int'($urandom_range(0, 2500));
      t2 = int'($urandom_range(0, 2500));
      run_txn("rand", a, b, t1, t2);
      if (n % 5 == 4) begin
        for (int k = 0; k < 2; k++) run_txn("rand_rep", a, b, t1, t2);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
